// File: rtl/axil_pkg.sv
// Shared constants for the AXI-Lite configuration master: register map,
// response codes and the sequencing FSM encoding.
package axil_pkg;

   localparam int unsigned OffCtrl   = 32'h00;
   localparam int unsigned OffStatus = 32'h04;
   localparam int unsigned OffVecA   = 32'h08;
   localparam int unsigned OffVecB   = 32'h0C;
   localparam int unsigned OffLen    = 32'h10;
   localparam int unsigned OffOut    = 32'h14;
   localparam int unsigned OffResult = 32'h18;

   localparam logic [1:0] RespOkay = 2'b00;

   typedef enum logic [2:0] {
      StIdle,
      StWr,
      StWrResp,
      StPollWait,
      StRdStatus,
      StRdResult,
      StFinish
   } state_e;

endpackage

// File: rtl/axil_wr_chan.sv
// Single AXI-Lite write: AW and W complete independently, then B is accepted.
module axil_wr_chan #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_data,
   output logic                idle,
   output logic                hs_last,
   output logic                resp_done,
   output logic [1:0]          resp,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   logic aw_hs, w_hs;

   assign aw_hs     = awvalid & awready;
   assign w_hs      = wvalid & wready;
   // The remaining address/data handshakes all complete on this edge.
   assign hs_last   = (awvalid | wvalid) & (~awvalid | awready) & (~wvalid | wready);
   assign resp_done = bvalid & bready;
   assign resp      = bresp;
   assign idle      = ~(awvalid | wvalid | bready);

   always_ff @(posedge clk) begin
      if (!rst) begin
         awaddr  <= '0;
         awvalid <= 1'b0;
         wdata   <= '0;
         wstrb   <= '0;
         wvalid  <= 1'b0;
         bready  <= 1'b0;
      end else begin
         if (req) begin
            awaddr  <= req_addr;
            wdata   <= req_data;
            wstrb   <= '1;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
         end else begin
            if (aw_hs) awvalid <= 1'b0;
            if (w_hs)  wvalid  <= 1'b0;
         end
         if (hs_last) begin
            bready <= 1'b1;
         end else if (resp_done) begin
            bready <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/axil_cfg_master.sv
// Programs a dot-product accelerator over AXI-Lite, polls STATUS, then reads RESULT.
module axil_cfg_master
   import axil_pkg::*;
#(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned POLL_GAP = 4,
   parameter int unsigned MAX_POLL = 255
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [DATA_W-1:0]   vec_a_addr,
   input  logic [DATA_W-1:0]   vec_b_addr,
   input  logic [DATA_W-1:0]   vec_len,
   input  logic [DATA_W-1:0]   out_addr,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [DATA_W-1:0]   result,
   output logic [ADDR_W-1:0]   awaddr,
   output logic                awvalid,
   input  logic                awready,
   output logic [DATA_W-1:0]   wdata,
   output logic [DATA_W/8-1:0] wstrb,
   output logic                wvalid,
   input  logic                wready,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready,
   output logic [ADDR_W-1:0]   araddr,
   output logic                arvalid,
   input  logic                arready,
   input  logic [DATA_W-1:0]   rdata,
   input  logic [1:0]          rresp,
   input  logic                rvalid,
   output logic                rready
);

   state_e            state_q, state_d;
   logic [2:0]        idx_q, idx_d;
   logic [DATA_W-1:0] a_q, a_d, b_q, b_d, len_q, len_d, out_q, out_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic              err_q, err_d;
   logic [31:0]       gap_q, gap_d, poll_q, poll_d;
   logic              arvalid_q, arvalid_d, rready_q, rready_d;
   logic [ADDR_W-1:0] araddr_q, araddr_d;

   logic              wr_req, wr_idle, wr_hs_last, wr_resp_done;
   logic [1:0]        wr_resp;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              rd_hs;

   assign rd_hs = rvalid & rready_q;

   axil_wr_chan #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_wr_chan (
      .clk       (clk),
      .rst       (rst),
      .req       (wr_req),
      .req_addr  (wr_addr),
      .req_data  (wr_data),
      .idle      (wr_idle),
      .hs_last   (wr_hs_last),
      .resp_done (wr_resp_done),
      .resp      (wr_resp),
      .awaddr    (awaddr),
      .awvalid   (awvalid),
      .awready   (awready),
      .wdata     (wdata),
      .wstrb     (wstrb),
      .wvalid    (wvalid),
      .wready    (wready),
      .bresp     (bresp),
      .bvalid    (bvalid),
      .bready    (bready)
   );

   // Write sequence: VEC_A, VEC_B, LEN, OUT, then CTRL.go.
   always_comb begin
      wr_addr = ADDR_W'(OffCtrl);
      wr_data = DATA_W'(1);
      unique case (idx_q)
         3'd0:    begin wr_addr = ADDR_W'(OffVecA); wr_data = a_q;   end
         3'd1:    begin wr_addr = ADDR_W'(OffVecB); wr_data = b_q;   end
         3'd2:    begin wr_addr = ADDR_W'(OffLen);  wr_data = len_q; end
         3'd3:    begin wr_addr = ADDR_W'(OffOut);  wr_data = out_q; end
         default: ;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      a_d       = a_q;
      b_d       = b_q;
      len_d     = len_q;
      out_d     = out_q;
      result_d  = result_q;
      err_d     = err_q;
      gap_d     = gap_q;
      poll_d    = poll_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      araddr_d  = araddr_q;
      wr_req    = 1'b0;

      if (arvalid_q && arready) begin
         arvalid_d = 1'b0;
         rready_d  = 1'b1;
      end
      if (rd_hs) rready_d = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (start) begin
               a_d      = vec_a_addr;
               b_d      = vec_b_addr;
               len_d    = vec_len;
               out_d    = out_addr;
               idx_d    = 3'd0;
               result_d = '0;
               err_d    = 1'b0;
               state_d  = (vec_len == '0) ? StFinish : StWr;
            end
         end
         StWr: begin
            wr_req = wr_idle;
            if (wr_hs_last) state_d = StWrResp;
         end
         StWrResp: begin
            if (wr_resp_done) begin
               if (wr_resp != RespOkay) begin
                  err_d    = 1'b1;
                  result_d = '0;
                  state_d  = StFinish;
               end else if (idx_q == 3'd4) begin
                  gap_d   = '0;
                  poll_d  = '0;
                  state_d = StPollWait;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StWr;
               end
            end
         end
         StPollWait: begin
            if (gap_q + 32'd1 >= POLL_GAP) begin
               gap_d   = '0;
               state_d = StRdStatus;
            end else begin
               gap_d = gap_q + 32'd1;
            end
         end
         StRdStatus: begin
            if (!arvalid_q && !rready_q) begin
               arvalid_d = 1'b1;
               araddr_d  = ADDR_W'(OffStatus);
            end
            if (rd_hs) begin
               if (rresp != RespOkay) begin
                  err_d    = 1'b1;
                  result_d = '0;
                  state_d  = StFinish;
               end else if (rdata[0]) begin
                  state_d = StRdResult;
               end else if (poll_q + 32'd1 >= MAX_POLL) begin
                  err_d    = 1'b1;
                  result_d = '0;
                  state_d  = StFinish;
               end else begin
                  poll_d  = poll_q + 32'd1;
                  state_d = StPollWait;
               end
            end
         end
         StRdResult: begin
            if (!arvalid_q && !rready_q) begin
               arvalid_d = 1'b1;
               araddr_d  = ADDR_W'(OffResult);
            end
            if (rd_hs) begin
               err_d    = (rresp != RespOkay);
               result_d = (rresp != RespOkay) ? '0 : rdata;
               state_d  = StFinish;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= StIdle;
         idx_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         len_q     <= '0;
         out_q     <= '0;
         result_q  <= '0;
         err_q     <= 1'b0;
         gap_q     <= '0;
         poll_q    <= '0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         araddr_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         a_q       <= a_d;
         b_q       <= b_d;
         len_q     <= len_d;
         out_q     <= out_d;
         result_q  <= result_d;
         err_q     <= err_d;
         gap_q     <= gap_d;
         poll_q    <= poll_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         araddr_q  <= araddr_d;
      end
   end

   assign busy    = (state_q != StIdle) && (state_q != StFinish);
   assign done    = (state_q == StFinish);
   assign err     = done & err_q;
   assign result  = result_q;
   assign arvalid = arvalid_q;
   assign rready  = rready_q;
   assign araddr  = araddr_q;

endmodule
